if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the PPCPU pipeline, directly upstream of ID.
- Owns the PC register and the instruction-memory request handshake.
- Owns the IF/ID pipeline register that supplies PC, IF_Inst and ID_Inst to the rest of the core.
- Handles hazard stalls (from the dependency unit that produces DEPEN) and branch/jump redirects resolved in EXE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction injected into IF/ID on flush or reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  one clock; reset is synchronous and active-high.
- Stall  in  1  hazard stall from the dependency unit; freezes PC and IF/ID.
- Redirect  in  1  taken branch/jump from EXE; flushes IF/ID.
- Redirect_PC  in  32  redirect target.
- IMem_Req  out  1  fetch request valid.
- IMem_Addr  out  32  fetch address; must stay stable while IMem_Req=1 and IMem_Ready=0.
- IMem_Ready  in  1  memory returns IMem_Data this cycle.
- IMem_Data  in  32  fetched instruction word.
- PC  out  32  current fetch PC.
- IF_Inst  out  32  instruction returned this cycle; NOP_INST when IMem_Ready=0.
- ID_Valid  out  1  IF/ID holds a real instruction.
- ID_PC  out  32  PC of the instruction in IF/ID.
- ID_Inst  out  32  instruction in IF/ID.

Behaviour:
- Reset values (synchronous, Reset=1 at a rising edge): PC=RESET_PC, ID_Valid=0, ID_Inst=NOP_INST, ID_PC=RESET_PC, IMem_Req=0, FSM=RST, skid buffer empty.
- FSM states:
  - RST: IMem_Req=0. Always moves to REQ on the next cycle.
  - REQ: IMem_Req=1, IMem_Addr=PC.
    - On Ready with no Stall: load IF/ID with {1, PC, IMem_Data} and set PC=PC+PC_STEP. Stay in REQ, so back-to-back fetch gives 1 instruction/cycle with zero-wait memory.
    - On Ready with Stall: capture IMem_Data into the skid buffer and move to HOLD. PC is not advanced.
  - HOLD: IMem_Req=0. When Stall drops, move the skid buffer into IF/ID, set PC=PC+PC_STEP, and return to REQ.
  - DRAIN: entered on Redirect while a request is outstanding (REQ with Ready=0).
    - IMem_Req stays 1 and IMem_Addr stays at the old address until Ready.
    - The returned data is discarded; PC is already the target; move to REQ.
- Fetch latency: the instruction appears in ID_Inst one cycle after the Ready cycle.
- Stall: IF/ID holds its value and ID_Valid is unchanged. PC is not incremented.
- Redirect priority, highest first: Reset > Redirect > Stall > normal.
- Redirect in any state except RST:
  - PC := {Redirect_PC[31:2], 2'b00}.
  - IF/ID := {0, Redirect_PC, NOP_INST}.
  - Skid buffer cleared.
  - Next state: REQ if no request is outstanding, or if Ready=1 this cycle (data dropped). Otherwise DRAIN.
- Redirect together with Stall: the redirect is still applied, and the flush overrides the freeze.
- Redirect while already in DRAIN: update PC to the new target; remain in DRAIN.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset asserted mid-request: any outstanding request is abandoned, and a Ready arriving while in RST is ignored.

Optional Feature:
- Macro: IF_PERF_EN.
- When defined, two extra output ports are added:
  - Fetch_Cnt[31:0]: increments on every instruction loaded into IF/ID with ID_Valid=1.
  - Stall_Cnt[31:0]: increments on every cycle with Stall=1 and FSM≠RST.
  - Both counters clear on Reset and wrap on overflow.
- When undefined, the ports and counters are absent and function is otherwise identical.

Decomposition:
- Shared package (ppcpu_pkg):
  - FSM state encoding: RST, REQ, HOLD, DRAIN.
  - NOP_INST constant.
  - PC_STEP constant.
  - Instruction/address width constants (32).
- One natural sub-module: if_id_reg, holding the IF/ID register with load/hold/flush control.
- The PC, FSM and skid buffer stay in if_stage.

Test Plan:
- Reset, then IMem_Ready=1 every cycle, memory returns Data=Addr^32'hA5A5_0000 -> PC goes 0,4,8,...; ID_Inst one cycle behind; ID_Valid=1 from the 2nd post-reset edge.
- Stall=1 for 3 cycles while Ready=1 at PC=8 -> FSM enters HOLD; IMem_Req=0; ID_PC=4 is held. On release, ID_PC=8 and ID_Inst=(8^A5A5_0000). PC=12 with no refetch of address 8.
- Redirect=1 with Redirect_PC=32'h0000_0103 while Ready=0 at PC=16 -> DRAIN. IMem_Addr stays 16 until Ready; that data is discarded. Next request is at 32'h100; ID_Valid=0 with ID_Inst=NOP.
- Redirect and Stall together at PC=20 -> PC=target, IF/ID flushed (ID_Valid=0), no freeze of the old instruction.
- Redirect to 32'hFFFF_FFFC with Ready=1 -> next PC is 0 (wrap).
- Reset asserted while in DRAIN with Ready=1 in the same cycle -> PC=RESET_PC, ID_Valid=0, IMem_Req=0 the next cycle; with IF_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/ppcpu_pkg.sv
// Shared PPCPU definitions: widths, fetch constants, IF state encoding, IF/ID payload.
package ppcpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [XLEN-1:0]   DEF_RESET_PC = 32'h0000_0000;
   localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0000;
   localparam int unsigned       DEF_PC_STEP  = 4;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } if_state_t;

   // IF/ID register update selector
   typedef enum logic [1:0] {
      IFID_HOLD  = 2'd0,
      IFID_LOAD  = 2'd1,
      IFID_FLUSH = 2'd2
   } ifid_op_t;

   // IF/ID payload
   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } if_id_t;

   // Word-align a branch target
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return a & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / flush control.
module if_id_reg
   import ppcpu_pkg::*;
#(
   parameter logic [XLEN-1:0]   RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
   input  logic     Clock,
   input  logic     Reset,
   input  ifid_op_t op,
   input  if_id_t   d,
   output if_id_t   q
);

   // Flush keeps the supplied PC but always drops validity and injects a NOP
   always_ff @(posedge Clock) begin
      if (Reset) begin
         q <= '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST};
      end else begin
         unique case (op)
            IFID_LOAD:  q <= d;
            IFID_FLUSH: q <= '{valid: 1'b0, pc: d.pc, inst: NOP_INST};
            default:    q <= q;
         endcase
      end
   end

endmodule

// File: rtl/if_stage.sv
// PPCPU instruction-fetch stage: PC, imem handshake FSM, skid buffer, IF/ID.
// Optional performance counters (Fetch_Cnt, Stall_Cnt) when IF_PERF_EN is defined.
module if_stage
   import ppcpu_pkg::*;
#(
   parameter logic [XLEN-1:0]   RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST,
   parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Redirect,
   input  logic [XLEN-1:0]   Redirect_PC,
   output logic              IMem_Req,
   output logic [XLEN-1:0]   IMem_Addr,
   input  logic              IMem_Ready,
   input  logic [INST_W-1:0] IMem_Data,
   output logic [XLEN-1:0]   PC,
   output logic [INST_W-1:0] IF_Inst,
   output logic              ID_Valid,
   output logic [XLEN-1:0]   ID_PC,
   output logic [INST_W-1:0] ID_Inst
`ifdef IF_PERF_EN
   ,
   output logic [31:0]       Fetch_Cnt,
   output logic [31:0]       Stall_Cnt
`endif
);

   if_state_t         state;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   addr_q;
   logic              req_q;
   logic [INST_W-1:0] skid_data;
   logic              skid_valid;

   logic [XLEN-1:0]   pc_inc;
   logic [XLEN-1:0]   redir_pc;

   ifid_op_t          ifid_op;
   if_id_t            ifid_d;
   if_id_t            ifid_q;

   assign pc_inc   = pc_q + XLEN'(PC_STEP);
   assign redir_pc = align_pc(Redirect_PC);

   assign PC        = pc_q;
   assign IMem_Addr = addr_q;
   assign IMem_Req  = req_q;
   assign IF_Inst   = (req_q && IMem_Ready) ? IMem_Data : NOP_INST;
   assign ID_Valid  = ifid_q.valid;
   assign ID_PC     = ifid_q.pc;
   assign ID_Inst   = ifid_q.inst;

   // IF/ID control decode: redirect flushes, stall freezes, a missing return inserts a bubble
   always_comb begin
      ifid_op = IFID_HOLD;
      ifid_d  = '{valid: 1'b1, pc: pc_q, inst: IMem_Data};
      unique case (state)
         ST_REQ: begin
            if (Redirect) begin
               ifid_op   = IFID_FLUSH;
               ifid_d.pc = Redirect_PC;
            end else if (!Stall) begin
               if (IMem_Ready) begin
                  ifid_op = IFID_LOAD;
               end else begin
                  ifid_op   = IFID_FLUSH;
                  ifid_d.pc = ifid_q.pc;
               end
            end
         end
         ST_HOLD: begin
            if (Redirect) begin
               ifid_op   = IFID_FLUSH;
               ifid_d.pc = Redirect_PC;
            end else if (!Stall) begin
               ifid_op      = IFID_LOAD;
               ifid_d.valid = skid_valid;
               ifid_d.inst  = skid_data;
            end
         end
         ST_DRAIN: begin
            if (Redirect) begin
               ifid_op   = IFID_FLUSH;
               ifid_d.pc = Redirect_PC;
            end else if (!Stall) begin
               ifid_op   = IFID_FLUSH;
               ifid_d.pc = ifid_q.pc;
            end
         end
         default: begin
            ifid_op = IFID_HOLD;
         end
      endcase
   end

   // Fetch FSM: PC, request/address registers and skid buffer
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= ST_RST;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         skid_data  <= NOP_INST;
         skid_valid <= 1'b0;
      end else begin
         unique case (state)
            ST_RST: begin
               state  <= ST_REQ;
               req_q  <= 1'b1;
               addr_q <= pc_q;
            end
            ST_REQ: begin
               if (Redirect) begin
                  pc_q       <= redir_pc;
                  skid_valid <= 1'b0;
                  skid_data  <= NOP_INST;
                  if (IMem_Ready) begin
                     addr_q <= redir_pc;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else if (IMem_Ready) begin
                  if (Stall) begin
                     skid_data  <= IMem_Data;
                     skid_valid <= 1'b1;
                     req_q      <= 1'b0;
                     state      <= ST_HOLD;
                  end else begin
                     pc_q   <= pc_inc;
                     addr_q <= pc_inc;
                  end
               end
            end
            ST_HOLD: begin
               if (Redirect) begin
                  pc_q       <= redir_pc;
                  addr_q     <= redir_pc;
                  req_q      <= 1'b1;
                  skid_valid <= 1'b0;
                  skid_data  <= NOP_INST;
                  state      <= ST_REQ;
               end else if (!Stall) begin
                  pc_q       <= pc_inc;
                  addr_q     <= pc_inc;
                  req_q      <= 1'b1;
                  skid_valid <= 1'b0;
                  state      <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               // Address held at the abandoned fetch until memory answers
               if (Redirect) begin
                  pc_q <= redir_pc;
                  if (IMem_Ready) begin
                     addr_q <= redir_pc;
                     state  <= ST_REQ;
                  end
               end else if (IMem_Ready) begin
                  addr_q <= pc_q;
                  state  <= ST_REQ;
               end
            end
            default: begin
               state <= ST_RST;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .Clock (Clock),
      .Reset (Reset),
      .op    (ifid_op),
      .d     (ifid_d),
      .q     (ifid_q)
   );

`ifdef IF_PERF_EN
   // Performance counters: valid IF/ID loads and non-reset stall cycles
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Fetch_Cnt <= 32'd0;
         Stall_Cnt <= 32'd0;
      end else begin
         if (ifid_op == IFID_LOAD && ifid_d.valid) begin
            Fetch_Cnt <= Fetch_Cnt + 32'd1;
         end
         if (Stall && state != ST_RST) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory returns Addr ^ 32'hA5A5_0000.
module tb_if_stage;

   logic        Clock;
   logic        Reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] Redirect_PC;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ready;
   logic [31:0] IMem_Data;
   logic [31:0] PC;
   logic [31:0] IF_Inst;
   logic        ID_Valid;
   logic [31:0] ID_PC;
   logic [31:0] ID_Inst;
`ifdef IF_PERF_EN
   logic [31:0] Fetch_Cnt;
   logic [31:0] Stall_Cnt;
`endif

   int total = 0;
   int bad   = 0;

   if_stage dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Stall       (Stall),
      .Redirect    (Redirect),
      .Redirect_PC (Redirect_PC),
      .IMem_Req    (IMem_Req),
      .IMem_Addr   (IMem_Addr),
      .IMem_Ready  (IMem_Ready),
      .IMem_Data   (IMem_Data),
      .PC          (PC),
      .IF_Inst     (IF_Inst),
      .ID_Valid    (ID_Valid),
      .ID_PC       (ID_PC),
      .ID_Inst     (ID_Inst)
`ifdef IF_PERF_EN
      ,
      .Fetch_Cnt   (Fetch_Cnt),
      .Stall_Cnt   (Stall_Cnt)
`endif
   );

   assign IMem_Data = IMem_Addr ^ 32'hA5A5_0000;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0; IMem_Ready = 1'b0;
      cyc(); cyc();
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
      total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", IMem_Req); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ID_Valid); end
      total++; if (ID_Inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=%h", ID_Inst, 32'h0); end
      total++; if (ID_PC !== 32'h0) begin bad++; $display("FAIL reset_idpc got=%h exp=%h", ID_PC, 32'h0); end
   endtask

   task automatic test_seq_fetch();
      Reset = 1'b0; IMem_Ready = 1'b1;
      cyc();
      total++; if (IMem_Req !== 1'b1) begin bad++; $display("FAIL seq_req1 got=%b exp=1", IMem_Req); end
      total++; if (IMem_Addr !== 32'h0) begin bad++; $display("FAIL seq_addr0 got=%h exp=%h", IMem_Addr, 32'h0); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL seq_valid_e1 got=%b exp=0", ID_Valid); end
      total++; if (IF_Inst !== 32'hA5A5_0000) begin bad++; $display("FAIL seq_ifinst got=%h exp=%h", IF_Inst, 32'hA5A5_0000); end
      cyc();
      total++; if (ID_Valid !== 1'b1) begin bad++; $display("FAIL seq_valid_e2 got=%b exp=1", ID_Valid); end
      total++; if (ID_Inst !== 32'hA5A5_0000) begin bad++; $display("FAIL seq_inst0 got=%h exp=%h", ID_Inst, 32'hA5A5_0000); end
      total++; if (PC !== 32'h4) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", PC, 32'h4); end
      cyc();
      total++; if (PC !== 32'h8) begin bad++; $display("FAIL seq_pc8 got=%h exp=%h", PC, 32'h8); end
      total++; if (ID_PC !== 32'h4) begin bad++; $display("FAIL seq_idpc4 got=%h exp=%h", ID_PC, 32'h4); end
      total++; if (ID_Inst !== 32'hA5A5_0004) begin bad++; $display("FAIL seq_inst4 got=%h exp=%h", ID_Inst, 32'hA5A5_0004); end
   endtask

   task automatic test_stall();
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, IMem_Req); end
         total++; if (ID_PC !== 32'h4) begin bad++; $display("FAIL stall_idpc[%0d] got=%h exp=%h", i, ID_PC, 32'h4); end
         total++; if (ID_Valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ID_Valid); end
         total++; if (PC !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, PC, 32'h8); end
      end
      Stall = 1'b0;
      cyc();
      total++; if (ID_PC !== 32'h8) begin bad++; $display("FAIL release_idpc got=%h exp=%h", ID_PC, 32'h8); end
      total++; if (ID_Inst !== 32'hA5A5_0008) begin bad++; $display("FAIL release_inst got=%h exp=%h", ID_Inst, 32'hA5A5_0008); end
      total++; if (PC !== 32'hC) begin bad++; $display("FAIL release_pc got=%h exp=%h", PC, 32'hC); end
      total++; if (IMem_Addr !== 32'hC) begin bad++; $display("FAIL release_addr got=%h exp=%h", IMem_Addr, 32'hC); end
      total++; if (IMem_Req !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", IMem_Req); end
   endtask

   task automatic test_redirect_drain();
      cyc();
      total++; if (PC !== 32'h10) begin bad++; $display("FAIL drain_pre_pc got=%h exp=%h", PC, 32'h10); end
      IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h0000_0103;
      cyc();
      Redirect = 1'b0;
      total++; if (PC !== 32'h100) begin bad++; $display("FAIL drain_pc got=%h exp=%h", PC, 32'h100); end
      total++; if (IMem_Addr !== 32'h10) begin bad++; $display("FAIL drain_addr got=%h exp=%h", IMem_Addr, 32'h10); end
      total++; if (IMem_Req !== 1'b1) begin bad++; $display("FAIL drain_req got=%b exp=1", IMem_Req); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", ID_Valid); end
      total++; if (ID_PC !== 32'h103) begin bad++; $display("FAIL drain_idpc got=%h exp=%h", ID_PC, 32'h103); end
      total++; if (ID_Inst !== 32'h0) begin bad++; $display("FAIL drain_inst got=%h exp=%h", ID_Inst, 32'h0); end
      cyc();
      total++; if (IMem_Addr !== 32'h10) begin bad++; $display("FAIL drain_hold_addr got=%h exp=%h", IMem_Addr, 32'h10); end
      total++; if (IF_Inst !== 32'h0) begin bad++; $display("FAIL drain_ifinst got=%h exp=%h", IF_Inst, 32'h0); end
      IMem_Ready = 1'b1;
      cyc();
      total++; if (IMem_Addr !== 32'h100) begin bad++; $display("FAIL drain_next_addr got=%h exp=%h", IMem_Addr, 32'h100); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL drain_discard got=%b exp=0", ID_Valid); end
      cyc();
      total++; if (ID_PC !== 32'h100) begin bad++; $display("FAIL drain_fetch_idpc got=%h exp=%h", ID_PC, 32'h100); end
      total++; if (ID_Inst !== 32'hA5A5_0100) begin bad++; $display("FAIL drain_fetch_inst got=%h exp=%h", ID_Inst, 32'hA5A5_0100); end
      total++; if (PC !== 32'h104) begin bad++; $display("FAIL drain_fetch_pc got=%h exp=%h", PC, 32'h104); end
   endtask

   task automatic test_redirect_stall();
      Redirect = 1'b1; Redirect_PC = 32'h10;
      cyc();
      Redirect = 1'b0;
      cyc();
      total++; if (PC !== 32'h14) begin bad++; $display("FAIL rs_pre_pc got=%h exp=%h", PC, 32'h14); end
      total++; if (ID_Valid !== 1'b1) begin bad++; $display("FAIL rs_pre_valid got=%b exp=1", ID_Valid); end
      Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h200;
      cyc();
      Stall = 1'b0; Redirect = 1'b0;
      total++; if (PC !== 32'h200) begin bad++; $display("FAIL rs_pc got=%h exp=%h", PC, 32'h200); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%b exp=0", ID_Valid); end
      total++; if (ID_PC !== 32'h200) begin bad++; $display("FAIL rs_idpc got=%h exp=%h", ID_PC, 32'h200); end
      total++; if (IMem_Addr !== 32'h200) begin bad++; $display("FAIL rs_addr got=%h exp=%h", IMem_Addr, 32'h200); end
      cyc();
      total++; if (ID_Inst !== 32'hA5A5_0200) begin bad++; $display("FAIL rs_fetch_inst got=%h exp=%h", ID_Inst, 32'hA5A5_0200); end
      total++; if (PC !== 32'h204) begin bad++; $display("FAIL rs_fetch_pc got=%h exp=%h", PC, 32'h204); end
   endtask

   task automatic test_wrap();
      Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
      cyc();
      Redirect = 1'b0;
      total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_tgt got=%h exp=%h", PC, 32'hFFFF_FFFC); end
      cyc();
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'h0); end
      total++; if (ID_PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_idpc got=%h exp=%h", ID_PC, 32'hFFFF_FFFC); end
      total++; if (ID_Inst !== 32'h5A5A_FFFC) begin bad++; $display("FAIL wrap_inst got=%h exp=%h", ID_Inst, 32'h5A5A_FFFC); end
`ifdef IF_PERF_EN
      total++; if (Fetch_Cnt !== 32'd8) begin bad++; $display("FAIL perf_fetch got=%0d exp=8", Fetch_Cnt); end
      total++; if (Stall_Cnt !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", Stall_Cnt); end
`endif
   endtask

   task automatic test_reset_in_drain();
      IMem_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h40;
      cyc();
      Redirect = 1'b0;
      total++; if (IMem_Addr !== 32'h0 || IMem_Req !== 1'b1 || PC !== 32'h40) begin
         bad++; $display("FAIL rd_drain got addr=%h req=%b pc=%h exp addr=0 req=1 pc=40", IMem_Addr, IMem_Req, PC);
      end
      Reset = 1'b1; IMem_Ready = 1'b1;
      cyc();
      Reset = 1'b0;
      total++; if (PC !== 32'h0) begin bad++; $display("FAIL rd_pc got=%h exp=%h", PC, 32'h0); end
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b exp=0", ID_Valid); end
      total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL rd_req got=%b exp=0", IMem_Req); end
      total++; if (ID_Inst !== 32'h0) begin bad++; $display("FAIL rd_inst got=%h exp=%h", ID_Inst, 32'h0); end
`ifdef IF_PERF_EN
      total++; if (Fetch_Cnt !== 32'd0) begin bad++; $display("FAIL rd_fetch_cnt got=%0d exp=0", Fetch_Cnt); end
      total++; if (Stall_Cnt !== 32'd0) begin bad++; $display("FAIL rd_stall_cnt got=%0d exp=0", Stall_Cnt); end
`endif
      cyc();
      total++; if (ID_Valid !== 1'b0) begin bad++; $display("FAIL rd_rst_ready got=%b exp=0", ID_Valid); end
      total++; if (IMem_Req !== 1'b1) begin bad++; $display("FAIL rd_req_back got=%b exp=1", IMem_Req); end
      cyc();
      total++; if (ID_Valid !== 1'b1 || ID_Inst !== 32'hA5A5_0000) begin
         bad++; $display("FAIL rd_refetch got valid=%b inst=%h exp valid=1 inst=a5a50000", ID_Valid, ID_Inst);
      end
      total++; if (PC !== 32'h4) begin bad++; $display("FAIL rd_refetch_pc got=%h exp=%h", PC, 32'h4); end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_redirect_drain();
      test_redirect_stall();
      test_wrap();
      test_reset_in_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
